tri_bus_reader_4bit: RTL and testbench



---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_wait_counter.sv | 40 ++++
 rtl/tri_bus_reader_4bit_chk.sv | 23 ++
 rtl/tri_bus_reader_4bit.sv | 155 +++++++++++++++
 tb/tb_tri_bus_reader_4bit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 4-bit tri-state bus reader: FSM states, bus width
// and the source-select one-hot decoder.
package bus_pkg;

    localparam int BUS_W   = 4;
    localparam int MAX_SRC = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    function automatic logic [MAX_SRC-1:0] onehot(input logic [3:0] sel);
        onehot = 16'h0001 << sel;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable down-counter with zero flag; times both the turnaround gap and the
// settle window of the bus reader.
module bus_wait_counter #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins over decrement; saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/tri_bus_reader_4bit_chk.sv
// Property checker for the bus reader: no bus contention and consistent
// valid/err qualification.
module tri_bus_reader_4bit_chk #(
    parameter int NUM_SRC = 4
) (
    input logic               clk,
    input logic               reset,
    input logic [NUM_SRC-1:0] drv_en_i,
    input logic               valid_i,
    input logic               err_i
);

    a_one_driver: assert property (@(posedge clk) disable iff (reset)
        $countones(drv_en_i) <= 1);

    // A driver may only be released to zero, never handed straight to another one.
    a_no_handover: assert property (@(posedge clk) disable iff (reset)
        (drv_en_i != {NUM_SRC{1'b0}}) |=> ((drv_en_i == {NUM_SRC{1'b0}}) || (drv_en_i == $past(drv_en_i))));

    a_err_qualified: assert property (@(posedge clk) disable iff (reset)
        err_i |-> valid_i);

endmodule

// File: rtl/tri_bus_reader_4bit.sv
// Reader for the shared 4-bit tri-state bus: owns the buffer enables, inserts a
// turnaround gap, lets the bus settle, captures, and returns the value via valid/ready.
module tri_bus_reader_4bit
    import bus_pkg::*;
#(
    parameter int NUM_SRC       = 4,
    parameter int SEL_W         = 2,
    parameter int TURNAROUND    = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic [SEL_W-1:0]   src_sel,
    input  logic [BUS_W-1:0]   bus_in,
    output logic [NUM_SRC-1:0] drv_en,
    output logic [BUS_W-1:0]   data_out,
    output logic               valid,
    input  logic               ready,
    output logic               err,
    output logic               busy
);

    localparam int MAX_WAIT = (TURNAROUND > SETTLE_CYCLES) ? TURNAROUND : SETTLE_CYCLES;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_SRC-1:0] drv_en_q, drv_en_d;
    logic [BUS_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    logic               cnt_load_s;
    logic [CNT_W-1:0]   cnt_load_val_s;
    logic               cnt_dec_s;
    logic               cnt_zero_s;
    logic               sel_bad_s;

    assign sel_bad_s = (32'(src_sel) >= 32'(NUM_SRC));

    bus_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (cnt_load_val_s),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state, output and counter-control decode for the read sequence.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        drv_en_d       = drv_en_q;
        data_d         = data_q;
        valid_d        = valid_q;
        err_d          = err_q;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = {CNT_W{1'b0}};
        cnt_dec_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                drv_en_d = {NUM_SRC{1'b0}};
                if (req) begin
                    sel_d = src_sel;
                    if (sel_bad_s) begin
                        // Nothing on the bus to read: report the error without enabling anyone.
                        state_d = ST_HOLD;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        data_d  = {BUS_W{1'b0}};
                    end else begin
                        state_d        = ST_TURN;
                        cnt_load_s     = 1'b1;
                        cnt_load_val_s = CNT_W'(TURNAROUND - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TURN: begin
                drv_en_d = {NUM_SRC{1'b0}};
                if (cnt_zero_s) begin
                    drv_en_d       = NUM_SRC'(onehot(4'(sel_q)));
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = CNT_W'(SETTLE_CYCLES);
                    state_d        = ST_DRIVE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (cnt_zero_s) begin
                    data_d   = bus_in;
                    drv_en_d = {NUM_SRC{1'b0}};
                    valid_d  = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_HOLD: begin
                drv_en_d = {NUM_SRC{1'b0}};
                if (ready) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                drv_en_d = {NUM_SRC{1'b0}};
                valid_d  = 1'b0;
                err_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= {SEL_W{1'b0}};
            drv_en_q <= {NUM_SRC{1'b0}};
            data_q   <= {BUS_W{1'b0}};
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            drv_en_q <= drv_en_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign drv_en   = drv_en_q;
    assign data_out = data_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_tri_bus_reader_4bit.sv
// Directed bench for tri_bus_reader_4bit: default, 3-source and long-turnaround
// instances, each with a behavioural bus fed by its own enables.
module tb_tri_bus_reader_4bit;

    logic       clk;
    logic       reset;
    logic       ready;
    logic       req_a, req_b, req_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic [3:0] bus_a, bus_b, bus_c;
    logic [3:0] drv_a, drv_c;
    logic [2:0] drv_b;
    logic [3:0] data_a, data_b, data_c;
    logic       valid_a, valid_b, valid_c;
    logic       err_a, err_b, err_c;
    logic       busy_a, busy_b, busy_c;

    int total = 0;
    int bad   = 0;

    function automatic logic [3:0] src_val(input int i);
        case (i)
            0:       src_val = 4'h5;
            1:       src_val = 4'hC;
            2:       src_val = 4'hA;
            default: src_val = 4'h3;
        endcase
    endfunction

    always_comb begin
        bus_a = 4'h0;
        for (int i = 0; i < 4; i++) if (drv_a[i]) bus_a = src_val(i);
    end
    always_comb begin
        bus_b = 4'h0;
        for (int i = 0; i < 3; i++) if (drv_b[i]) bus_b = src_val(i);
    end
    always_comb begin
        bus_c = 4'h0;
        for (int i = 0; i < 4; i++) if (drv_c[i]) bus_c = src_val(i);
    end

    tri_bus_reader_4bit dut (
        .clk(clk), .reset(reset), .req(req_a), .src_sel(sel_a), .bus_in(bus_a),
        .drv_en(drv_a), .data_out(data_a), .valid(valid_a), .ready(ready),
        .err(err_a), .busy(busy_a)
    );
    tri_bus_reader_4bit #(.NUM_SRC(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset(reset), .req(req_b), .src_sel(sel_b), .bus_in(bus_b),
        .drv_en(drv_b), .data_out(data_b), .valid(valid_b), .ready(ready),
        .err(err_b), .busy(busy_b)
    );
    tri_bus_reader_4bit #(.TURNAROUND(3), .SETTLE_CYCLES(0)) dut6 (
        .clk(clk), .reset(reset), .req(req_c), .src_sel(sel_c), .bus_in(bus_c),
        .drv_en(drv_c), .data_out(data_c), .valid(valid_c), .ready(ready),
        .err(err_c), .busy(busy_c)
    );

    tri_bus_reader_4bit_chk #(.NUM_SRC(4)) chk_a (
        .clk(clk), .reset(reset), .drv_en_i(drv_a), .valid_i(valid_a), .err_i(err_a));
    tri_bus_reader_4bit_chk #(.NUM_SRC(3)) chk_b (
        .clk(clk), .reset(reset), .drv_en_i(drv_b), .valid_i(valid_b), .err_i(err_b));
    tri_bus_reader_4bit_chk #(.NUM_SRC(4)) chk_c (
        .clk(clk), .reset(reset), .drv_en_i(drv_c), .valid_i(valid_c), .err_i(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ready = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        sel_a = 2'd0; sel_b = 2'd0; sel_c = 2'd0;
        tick(); tick();
        total++;
        if ({drv_a, data_a, valid_a, err_a, busy_a} !== 11'b0) begin
            $display("FAIL reset_a got=%b exp=%b", {drv_a, data_a, valid_a, err_a, busy_a}, 11'b0);
            bad++;
        end
        total++;
        if ({drv_b, data_b, valid_b, err_b, busy_b, drv_c, data_c, valid_c, err_c, busy_c} !== 21'b0) begin
            $display("FAIL reset_bc got=%b exp=0",
                     {drv_b, data_b, valid_b, err_b, busy_b, drv_c, data_c, valid_c, err_c, busy_c});
            bad++;
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [3:0] exp_drv [4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000};
        logic       exp_vld [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        ready = 1'b1; sel_a = 2'd2; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if ({drv_a, valid_a, busy_a} !== {exp_drv[k], exp_vld[k], 1'b1}) begin
                $display("FAIL basic_e%0d drv/valid/busy got=%b exp=%b", k,
                         {drv_a, valid_a, busy_a}, {exp_drv[k], exp_vld[k], 1'b1});
                bad++;
            end
            if (k < 3) tick();
        end
        total++;
        if ({data_a, err_a} !== {4'hA, 1'b0}) begin
            $display("FAIL basic_data got=%h err=%b exp=a err=0", data_a, err_a);
            bad++;
        end
        tick();
        total++;
        if ({valid_a, busy_a, drv_a} !== 6'b0) begin
            $display("FAIL basic_handshake valid=%b busy=%b drv=%b exp=0", valid_a, busy_a, drv_a);
            bad++;
        end
    endtask

    task automatic test_hold();
        ready = 1'b0; sel_a = 2'd2; req_a = 1'b1;
        tick();
        sel_a = 2'd0;
        tick(); tick(); tick();
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({valid_a, data_a, drv_a, busy_a} !== {1'b1, 4'hA, 4'b0000, 1'b1}) begin
                $display("FAIL hold_c%0d valid=%b data=%h drv=%b busy=%b exp=1/a/0000/1", k,
                         valid_a, data_a, drv_a, busy_a);
                bad++;
            end
            if (k < 5) tick();
        end
        ready = 1'b1; req_a = 1'b0;
        tick();
        total++;
        if ({valid_a, busy_a} !== 2'b00) begin
            $display("FAIL hold_release valid=%b busy=%b exp=00", valid_a, busy_a);
            bad++;
        end
        tick();
        total++;
        if ({busy_a, drv_a} !== 5'b0) begin
            $display("FAIL hold_no_queue busy=%b drv=%b exp=0", busy_a, drv_a);
            bad++;
        end
    endtask

    task automatic test_err();
        ready = 1'b1; sel_b = 2'd2; req_b = 1'b1;
        tick();
        req_b = 1'b0;
        tick(); tick(); tick();
        total++;
        if ({valid_b, data_b, err_b} !== {1'b1, 4'hA, 1'b0}) begin
            $display("FAIL err_pre valid=%b data=%h err=%b exp=1/a/0", valid_b, data_b, err_b);
            bad++;
        end
        tick();
        sel_b = 2'd3; req_b = 1'b1;
        tick();
        req_b = 1'b0;
        total++;
        if ({drv_b, valid_b, err_b, data_b, busy_b} !== {3'b000, 1'b1, 1'b1, 4'h0, 1'b1}) begin
            $display("FAIL err_flag drv=%b valid=%b err=%b data=%h busy=%b exp=000/1/1/0/1",
                     drv_b, valid_b, err_b, data_b, busy_b);
            bad++;
        end
        tick();
        total++;
        if ({drv_b, valid_b, err_b, busy_b} !== 6'b0) begin
            $display("FAIL err_clear drv=%b valid=%b err=%b busy=%b exp=0", drv_b, valid_b, err_b, busy_b);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        int         cur;
        int         xfers;
        ready = 1'b1; cur = 0; sel_a = 2'd0; req_a = 1'b1; xfers = 0; prev = 4'b0000;
        for (int cyc = 0; cyc < 60 && xfers < 4; cyc++) begin
            tick();
            total++;
            if ($countones(drv_a) > 1 || (drv_a != 4'b0000 && prev != 4'b0000 && drv_a != prev)) begin
                $display("FAIL b2b_contention cyc=%0d drv=%b prev=%b", cyc, drv_a, prev);
                bad++;
            end
            if (drv_a != 4'b0000 && prev == 4'b0000) begin
                total++;
                if (drv_a !== (4'b0001 << cur)) begin
                    $display("FAIL b2b_enable got=%b exp=%b", drv_a, 4'b0001 << cur);
                    bad++;
                end
            end
            if (valid_a) begin
                total++;
                if (data_a !== src_val(cur)) begin
                    $display("FAIL b2b_data xfer=%0d got=%h exp=%h", xfers, data_a, src_val(cur));
                    bad++;
                end
                xfers++;
                cur   = 1 - cur;
                sel_a = 2'(cur);
            end
            prev = drv_a;
        end
        total++;
        if (xfers != 4) begin
            $display("FAIL b2b_timeout got=%0d exp=4 transfers", xfers);
            bad++;
        end
        req_a = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        ready = 1'b1; sel_a = 2'd3; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        total++;
        if (drv_a !== 4'b1000) begin
            $display("FAIL rstmid_drive got=%b exp=1000", drv_a);
            bad++;
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({drv_a, valid_a, busy_a} !== 6'b0) begin
            $display("FAIL rstmid_async drv=%b valid=%b busy=%b exp=0", drv_a, valid_a, busy_a);
            bad++;
        end
        #1 reset = 1'b0;
        tick();
        total++;
        if ({drv_a, busy_a} !== 5'b0) begin
            $display("FAIL rstmid_idle drv=%b busy=%b exp=0", drv_a, busy_a);
            bad++;
        end
        sel_a = 2'd1; req_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick(); tick(); tick();
        total++;
        if ({valid_a, data_a} !== {1'b1, 4'hC}) begin
            $display("FAIL rstmid_after valid=%b data=%h exp=1/c", valid_a, data_a);
            bad++;
        end
        tick();
    endtask

    task automatic test_long_turn();
        logic [3:0] exp_drv [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        logic       exp_vld [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ready = 1'b1; sel_c = 2'd1; req_c = 1'b1;
        tick();
        req_c = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({drv_c, valid_c, busy_c} !== {exp_drv[k], exp_vld[k], 1'b1}) begin
                $display("FAIL long_e%0d drv/valid/busy got=%b exp=%b", k,
                         {drv_c, valid_c, busy_c}, {exp_drv[k], exp_vld[k], 1'b1});
                bad++;
            end
            if (k < 4) tick();
        end
        total++;
        if ({data_c, err_c} !== {4'hC, 1'b0}) begin
            $display("FAIL long_data got=%h err=%b exp=c err=0", data_c, err_c);
            bad++;
        end
        tick();
        total++;
        if ({valid_c, busy_c} !== 2'b00) begin
            $display("FAIL long_release valid=%b busy=%b exp=00", valid_c, busy_c);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_err();
        test_back_to_back();
        test_reset_mid();
        test_long_turn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
